vert_buf_writer: RTL
====================

VERT_BUF_WRITER -- requirements
Module: vert_buf_writer

Interface
REQ-001 Parameter MAX_VERT, default 8192, meaning vertex memory depth in vertices.
REQ-002 Parameter MAX_VERT_BUF, default 256, meaning number of buffer descriptor slots.
REQ-003 Parameter VTX_W, default 108, meaning vertex word width (3x32 position + 3x4 colour).
REQ-004 Parameter VIDX_W, default 8, meaning width of vertex count and buffer ID.
REQ-005 clk  in  1  system clock; the block uses this single clock.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 hdr_valid  in  1  vertex buffer header present (level from SPI front-end, synchronised to clk).
REQ-008 hdr_id  in  VIDX_W  buffer ID allocated by the SPI front-end.
REQ-009 hdr_base  in  log2(MAX_VERT)  first vertex memory address of the buffer.
REQ-010 hdr_count  in  VIDX_W  number of vertices in the buffer.
REQ-011 vert_valid  in  1  vertex present (level, held for one or more cycles).
REQ-012 vert_in  in  VTX_W  vertex word.
REQ-013 mem_we / mem_addr / mem_wdata  out  1 / log2(MAX_VERT) / VTX_W  vertex memory write port.
REQ-014 desc_we / desc_addr / desc_wdata  out  1 / VIDX_W / log2(MAX_VERT)+VIDX_W  descriptor table write port, wdata = {base, count}.
REQ-015 done  out  1  single-cycle pulse when a buffer is committed.
REQ-016 status_clr  in  1  clears the sticky error bits.
REQ-017 status  out  4  {extra_vert, abort, overflow, busy}, MSB first; feeds the SPI status nybble.

Function
REQ-018 hdr_valid and vert_valid SHALL be rising-edge detected with one registered history bit each; only a 0->1 transition is an event.
REQ-019 FSM states SHALL be IDLE, RECV, COMMIT.
REQ-020 IDLE + header event: latch id, base, count; index := 0; go to RECV; if count == 0, go directly to COMMIT.
REQ-021 Header event with base + count > MAX_VERT: set overflow; latch the header; suppress all mem_we for that buffer; still commit its descriptor.
REQ-022 RECV + vertex event: mem_we = 1 on the next cycle, with mem_addr = base + index and mem_wdata = vert_in captured at the event; index increments.
REQ-023 Address arithmetic SHALL be unsigned log2(MAX_VERT)+1 bits; no wrap-around write is ever issued.
REQ-024 When index reaches count after the last vertex: go to COMMIT.
REQ-025 COMMIT lasts exactly one cycle: desc_we = 1, desc_addr = id, desc_wdata = {base, count}, done = 1; then go to IDLE.
REQ-026 Vertex event in IDLE or COMMIT: discard it (no mem_we); set extra_vert.
REQ-027 Header event in RECV: set abort; do not commit the old buffer; restart RECV with the new header in the same cycle.
REQ-028 Header and vertex events in the same cycle: the header wins; the vertex is discarded and extra_vert is not set.
REQ-029 busy = 1 whenever the state is not IDLE.
REQ-030 status_clr clears overflow, abort and extra_vert on the next edge; a same-cycle set wins over the clear.
REQ-031 mem_we, desc_we and done SHALL be registered and never asserted for more than one cycle per event.

Reset
REQ-032 Asserting rst_n low SHALL immediately force state IDLE and zero all outputs and edge-history bits, regardless of clk.
REQ-033 A reset mid-buffer SHALL abandon the buffer with no descriptor write; memory contents are untouched.
REQ-034 After deassertion, an input already held high SHALL not generate an event until it goes low and then high again.

Configuration
REQ-035 Macro VBW_CHECKSUM_EN: when defined, add output checksum[31:0]: XOR of all 32-bit slices of each written vertex (zero-padded to a 32-bit multiple), cleared at header and valid while done = 1.
REQ-036 Without VBW_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Header id=3, base=0x010, count=2, then two vertices A, B -> writes 0x010=A and 0x011=B, one cycle after each event; then desc_we with addr 3, wdata {0x010, 2}; done pulse; status=0000.
REQ-038 Header count=0, id=5 -> no mem_we; COMMIT the cycle after the header; desc {base, 0} at addr 5.
REQ-039 Header base=8190, count=4 -> overflow set (status=0011 during RECV); zero mem_we over 4 vertices; descriptor committed; status=0010 after.
REQ-040 Header count=3, one vertex, then a new header -> abort set; first buffer has no desc_we; second buffer completes normally.
REQ-041 vert_valid held high 5 cycles -> exactly one mem_we; a vertex while IDLE -> extra_vert=1; status_clr -> 0000.
REQ-042 rst_n low mid-RECV, asynchronous to clk -> outputs zero immediately; no descriptor write; a following header works normally.

Source files
------------

// File: rtl/vert_buf_writer.sv
// Vertex buffer writer: streams vertices into vertex memory and commits one descriptor per buffer.
// Optional feature macro: VBW_CHECKSUM_EN adds a 32-bit XOR checksum output.
module vert_buf_writer #(
  parameter int MAX_VERT     = 8192,
  parameter int MAX_VERT_BUF = 256,
  parameter int VTX_W        = 108,
  parameter int VIDX_W       = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                hdr_valid,
  input  logic [VIDX_W-1:0]                   hdr_id,
  input  logic [$clog2(MAX_VERT)-1:0]         hdr_base,
  input  logic [VIDX_W-1:0]                   hdr_count,
  input  logic                                vert_valid,
  input  logic [VTX_W-1:0]                    vert_in,
  output logic                                mem_we,
  output logic [$clog2(MAX_VERT)-1:0]         mem_addr,
  output logic [VTX_W-1:0]                    mem_wdata,
  output logic                                desc_we,
  output logic [VIDX_W-1:0]                   desc_addr,
  output logic [$clog2(MAX_VERT)+VIDX_W-1:0]  desc_wdata,
  output logic                                done,
  input  logic                                status_clr,
`ifdef VBW_CHECKSUM_EN
  output logic [31:0]                         checksum,
`endif
  output logic [3:0]                          status
);

  localparam int AW = $clog2(MAX_VERT);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, COMMIT = 2'd2} state_t;

  if (MAX_VERT_BUF > (1 << VIDX_W)) begin : g_bad_cfg
    $error("MAX_VERT_BUF does not fit in VIDX_W bits");
  end

  state_t              r_state, w_state_nx;
  logic                r_hdr_d, r_hdr_arm, r_vert_d, r_vert_arm;
  logic [VIDX_W-1:0]   r_id, r_count, r_idx, w_idx_inc;
  logic [AW-1:0]       r_base;
  logic                r_sup;
  logic                r_ovf, r_abort, r_extra, r_busy;
  logic                r_mem_we, r_desc_we, r_done;
  logic [AW-1:0]       r_mem_addr;
  logic [VTX_W-1:0]    r_mem_wdata;
  logic [VIDX_W-1:0]   r_desc_addr;
  logic [AW+VIDX_W-1:0] r_desc_wdata;
  logic                w_hdr_ev, w_vert_ev, w_hdr_ovf, w_wr, w_adv, w_set_extra;
  logic [AW:0]         w_hdr_end, w_addr;

  // The arm bit keeps an input that is already high out of reset from looking like a new edge.
  assign w_hdr_ev  = hdr_valid  & ~r_hdr_d  & r_hdr_arm;
  assign w_vert_ev = vert_valid & ~r_vert_d & r_vert_arm;
  assign w_hdr_end = {1'b0, hdr_base} + (AW+1)'(hdr_count);
  assign w_hdr_ovf = w_hdr_end > (AW+1)'(MAX_VERT);
  assign w_addr    = {1'b0, r_base} + (AW+1)'(r_idx);
  assign w_idx_inc = r_idx + VIDX_W'(1);

  // Edge-history and arming bits for the two level inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_d    <= 1'b0;
      r_hdr_arm  <= 1'b0;
      r_vert_d   <= 1'b0;
      r_vert_arm <= 1'b0;
    end else begin
      r_hdr_d    <= hdr_valid;
      r_hdr_arm  <= r_hdr_arm | ~hdr_valid;
      r_vert_d   <= vert_valid;
      r_vert_arm <= r_vert_arm | ~vert_valid;
    end
  end

  // Next-state and per-cycle control decode; a header event overrides everything else
  always_comb begin
    w_state_nx  = r_state;
    w_wr        = 1'b0;
    w_adv       = 1'b0;
    w_set_extra = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nx  = IDLE;
        w_set_extra = w_vert_ev;
      end
      RECV: begin
        if (w_vert_ev) begin
          w_adv = 1'b1;
          w_wr  = ~r_sup & (w_addr < (AW+1)'(MAX_VERT));
          if (w_idx_inc == r_count) begin
            w_state_nx = COMMIT;
          end else begin
            w_state_nx = RECV;
          end
        end else begin
          w_state_nx = RECV;
        end
      end
      COMMIT: begin
        w_state_nx  = IDLE;
        w_set_extra = w_vert_ev;
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_hdr_ev) begin
      w_wr        = 1'b0;
      w_adv       = 1'b0;
      w_set_extra = 1'b0;
      w_state_nx  = (hdr_count == {VIDX_W{1'b0}}) ? COMMIT : RECV;
    end else begin
      w_set_extra = w_set_extra & ~w_hdr_ev;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Buffer context, registered outputs and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id         <= '0;
      r_base       <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_sup        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_desc_we    <= 1'b0;
      r_desc_addr  <= '0;
      r_desc_wdata <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_ovf        <= 1'b0;
      r_abort      <= 1'b0;
      r_extra      <= 1'b0;
    end else begin
      if (w_hdr_ev) begin
        r_id    <= hdr_id;
        r_base  <= hdr_base;
        r_count <= hdr_count;
        r_idx   <= '0;
        r_sup   <= w_hdr_ovf;
      end else if (w_adv) begin
        r_idx <= w_idx_inc;
      end
      r_mem_we <= w_wr;
      if (w_wr) begin
        r_mem_addr  <= w_addr[AW-1:0];
        r_mem_wdata <= vert_in;
      end
      r_desc_we <= (w_state_nx == COMMIT);
      r_done    <= (w_state_nx == COMMIT);
      if (w_state_nx == COMMIT) begin
        r_desc_addr  <= w_hdr_ev ? hdr_id : r_id;
        r_desc_wdata <= w_hdr_ev ? {hdr_base, hdr_count} : {r_base, r_count};
      end
      r_busy  <= (w_state_nx != IDLE);
      r_ovf   <= (w_hdr_ev & w_hdr_ovf) | (r_ovf & ~status_clr);
      r_abort <= (w_hdr_ev & (r_state == RECV)) | (r_abort & ~status_clr);
      r_extra <= w_set_extra | (r_extra & ~status_clr);
    end
  end

`ifdef VBW_CHECKSUM_EN
  localparam int NSL = (VTX_W + 31) / 32;

  function automatic logic [31:0] fold32(input logic [VTX_W-1:0] v);
    logic [NSL*32-1:0] pad;
    logic [31:0]       acc;
    pad            = '0;
    pad[VTX_W-1:0] = v;
    acc            = 32'h0000_0000;
    for (int i = 0; i < NSL; i++) begin
      acc = acc ^ pad[i*32 +: 32];
    end
    return acc;
  endfunction

  logic [31:0] r_csum;

  // Running XOR of every vertex actually written for the current buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= 32'h0000_0000;
    end else if (w_hdr_ev) begin
      r_csum <= 32'h0000_0000;
    end else if (w_wr) begin
      r_csum <= r_csum ^ fold32(vert_in);
    end else begin
      r_csum <= r_csum;
    end
  end

  assign checksum = r_csum;
`endif

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign desc_we    = r_desc_we;
  assign desc_addr  = r_desc_addr;
  assign desc_wdata = r_desc_wdata;
  assign done       = r_done;
  assign status     = {r_extra, r_abort, r_ovf, r_busy};

endmodule
